sample_capture_buffer: RTL
==========================

Name: sample_capture_buffer

Overview:
- Capture stage directly downstream of channel_trigger.
- Stores one WIDTH-bit sample of the probed bus per clock into an on-chip sample RAM while channel_trigger's o_run is high, and records the sample index at which the trigger fired.
- Once capture ends, exposes the stored samples through a simple request/valid readout port for the host interface.

Parameters:
- WIDTH, 8: sample width in bits; matches the channel_trigger data width.
- DEPTH_LOG2, 10: log2 of RAM depth; DEPTH = 2**DEPTH_LOG2 samples.

Ports:
- clk  in  1  sample clock, shared with channel_trigger.
- internal_reset  in  1  synchronous, active-high reset.
- i_data  in  WIDTH  probed bus; same signal fed to channel_trigger.
- i_run  in  1  from channel_trigger o_run; capture window.
- i_trig  in  1  from channel_trigger o_trig; trigger event marker.
- i_rd_req  in  1  readout request, one sample per high cycle.
- o_rd_data  out  WIDTH  readout sample.
- o_rd_valid  out  1  o_rd_data valid this cycle.
- o_busy  out  1  in CAPTURE state.
- o_done  out  1  capture complete; readout permitted.
- o_full  out  1  capture stopped because RAM filled.
- o_count  out  DEPTH_LOG2+1  number of stored samples, 0..DEPTH.
- o_trig_pos  out  DEPTH_LOG2  sample index of first i_trig in window.
- o_trig_seen  out  1  o_trig_pos is valid.

Behaviour:
- Reset (internal_reset=1 at posedge): state=IDLE.
- Reset values: all outputs 0, write pointer 0, read pointer 0. RAM contents not cleared.
- Reset applies mid-capture and mid-readout; takes priority over every other event.
- States: IDLE, CAPTURE, DONE, READOUT.
- IDLE:
  - i_run=1 at posedge -> write i_data at address 0 that same edge, count=1, go CAPTURE.
  - The first sample is the one present in the cycle i_run is first seen high.
  - i_rd_req ignored.
- CAPTURE:
  - Each posedge with i_run=1 and count<DEPTH: write i_data at address count, count+=1.
  - i_run=0 at posedge -> no write; go DONE; o_full=0.
  - count reaches DEPTH -> go DONE on the same edge as the DEPTH-th write; o_full=1. Further i_run is ignored.
  - o_busy=1 only in CAPTURE.
- Trigger marking:
  - First cycle within the window (IDLE-entry cycle or CAPTURE) with i_trig=1 and i_run=1: o_trig_pos = index of the sample written that cycle; o_trig_seen=1.
  - Later i_trig pulses are ignored.
  - i_trig while i_run=0 is ignored.
- DONE:
  - o_done=1; o_count frozen.
  - i_run ignored; no new capture until readout completes or reset.
  - i_rd_req=1 -> go READOUT and issue a read of address 0.
- READOUT:
  - Read latency is 1 cycle (registered RAM). i_rd_req high at edge N -> o_rd_data/o_rd_valid=1 after edge N+1; read pointer increments at edge N.
  - i_rd_req may be held high continuously for one sample per cycle, or pulsed.
  - o_rd_valid=0 in any cycle without a matching request.
  - After the request for index count-1 is accepted, further i_rd_req are ignored.
  - The final o_rd_valid pulse still occurs. On the following edge: go IDLE; clear count, o_done, o_full, o_trig_seen and o_trig_pos.
  - count=0 cannot occur in DONE, because entering CAPTURE writes one sample.
- Widths: count is DEPTH_LOG2+1 bits and never wraps. RAM address = count[DEPTH_LOG2-1:0].
- Simultaneous i_run falling and count reaching DEPTH: treated as full (o_full=1).

Optional Feature:
- Macro: CAPTURE_DECIM_EN.
- When defined:
  - Adds input i_decim [7:0].
  - A sample is stored on the first eligible cycle, then every i_decim+1 cycles while i_run=1. The prescaler restarts on IDLE->CAPTURE.
  - i_decim=0 is equivalent to no decimation.
  - i_trig marks the next stored sample index. If the window ends first, the trigger is not marked.
- When undefined: no i_decim port; one sample stored per cycle.

Test Plan:
- Reset; i_run high 4 cycles with i_data=15,17,13,22; i_trig on 2nd cycle -> o_count=4, o_trig_pos=1, o_trig_seen=1, o_done=1, o_full=0.
- After that capture, hold i_rd_req high 4 cycles -> o_rd_valid on 4 consecutive cycles with 15,17,13,22; then state IDLE, o_done=0, o_count=0.
- DEPTH_LOG2=3, i_run high 12 cycles with incrementing data 0.. -> o_count=8, o_full=1, readout 0..7; extra i_rd_req gives no o_rd_valid.
- internal_reset asserted for 1 cycle after 3 samples of capture -> all outputs 0; a new i_run window restarts at index 0.
- i_trig with i_run=0, then a window with no trig -> o_trig_seen=0 at o_done.
- CAPTURE_DECIM_EN, i_decim=2, i_run high 9 cycles, data=cycle index 0..8 -> o_count=3, readout 0,3,6.

Source files
------------

// File: rtl/sample_capture_if.sv
// Bus bundle for sample_capture_buffer: capture inputs, readout port and status.
// When CAPTURE_DECIM_EN is defined the bundle also carries the decimation control i_decim.
interface sample_capture_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic [WIDTH-1:0]      i_data;
  logic                  i_run;
  logic                  i_trig;
  logic                  i_rd_req;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]            i_decim;
`endif
  logic [WIDTH-1:0]      o_rd_data;
  logic                  o_rd_valid;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_full;
  logic [DEPTH_LOG2:0]   o_count;
  logic [DEPTH_LOG2-1:0] o_trig_pos;
  logic                  o_trig_seen;

  // Trigger/host side: drives capture inputs and read requests.
  modport master (
    output i_data, i_run, i_trig, i_rd_req,
`ifdef CAPTURE_DECIM_EN
    output i_decim,
`endif
    input  o_rd_data, o_rd_valid, o_busy, o_done, o_full, o_count, o_trig_pos, o_trig_seen
  );

  // Capture buffer side.
  modport slave (
    input  i_data, i_run, i_trig, i_rd_req,
`ifdef CAPTURE_DECIM_EN
    input  i_decim,
`endif
    output o_rd_data, o_rd_valid, o_busy, o_done, o_full, o_count, o_trig_pos, o_trig_seen
  );
endinterface

// File: rtl/sample_capture_buffer.sv
// sample_capture_buffer: records the probed bus into a sample RAM during the
// channel_trigger run window, remembers the first trigger index, then serves the
// stored samples through a request/valid readout port.
// Optional feature macro: CAPTURE_DECIM_EN (adds i_decim sample decimation).
module sample_capture_buffer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic             clk,
  input  logic             internal_reset,
  sample_capture_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned AW    = DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE,
    ST_READOUT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            full_q, full_d;
  logic [AW-1:0]   trig_pos_q, trig_pos_d;
  logic            trig_seen_q, trig_seen_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q;

  logic            wr_en_c;
  logic [AW-1:0]   wr_addr_c;
  logic            rd_en_c;
  logic            store_c;
  logic            trig_hit_c;

`ifdef CAPTURE_DECIM_EN
  logic [7:0]      pre_q, pre_d;
  logic            trig_pend_q, trig_pend_d;
`endif

  // Decide whether this CAPTURE cycle stores a sample and whether a trigger applies to it.
  always_comb begin
`ifdef CAPTURE_DECIM_EN
    store_c    = (pre_q >= bus.i_decim);
    trig_hit_c = bus.i_trig | trig_pend_q;
`else
    store_c    = 1'b1;
    trig_hit_c = bus.i_trig;
`endif
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    full_d      = full_q;
    trig_pos_d  = trig_pos_q;
    trig_seen_d = trig_seen_q;
    rd_pend_d   = 1'b0;
    rd_valid_d  = rd_pend_q;
    wr_en_c     = 1'b0;
    wr_addr_c   = count_q[AW-1:0];
    rd_en_c     = 1'b0;
`ifdef CAPTURE_DECIM_EN
    pre_d       = pre_q;
    trig_pend_d = trig_pend_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // First sample of the window is stored unconditionally at address 0.
        if (bus.i_run) begin
          wr_en_c   = 1'b1;
          wr_addr_c = '0;
          count_d   = CW'(1);
          state_d   = ST_CAPTURE;
          if (bus.i_trig) begin
            trig_pos_d  = '0;
            trig_seen_d = 1'b1;
          end
`ifdef CAPTURE_DECIM_EN
          pre_d       = 8'd0;
          trig_pend_d = 1'b0;
`endif
        end
      end

      ST_CAPTURE: begin
        if (!bus.i_run) begin
          // Window closed before the RAM filled; a pending trigger is dropped.
          state_d = ST_DONE;
          full_d  = 1'b0;
`ifdef CAPTURE_DECIM_EN
          trig_pend_d = 1'b0;
`endif
        end else if (store_c) begin
          wr_en_c = 1'b1;
          count_d = count_q + CW'(1);
          if (trig_hit_c && !trig_seen_q) begin
            trig_pos_d  = count_q[AW-1:0];
            trig_seen_d = 1'b1;
          end
`ifdef CAPTURE_DECIM_EN
          pre_d       = 8'd0;
          trig_pend_d = 1'b0;
`endif
          // The DEPTH-th write ends capture even if i_run is still high.
          if (count_q == CW'(DEPTH - 1)) begin
            state_d = ST_DONE;
            full_d  = 1'b1;
`ifdef CAPTURE_DECIM_EN
            trig_pend_d = 1'b0;
`endif
          end
        end else begin
`ifdef CAPTURE_DECIM_EN
          pre_d = pre_q + 8'd1;
          if (bus.i_trig && !trig_seen_q) begin
            trig_pend_d = 1'b1;
          end
`endif
        end
      end

      ST_DONE: begin
        if (bus.i_rd_req) begin
          rd_en_c   = 1'b1;
          rd_ptr_d  = rd_ptr_q + CW'(1);
          rd_pend_d = 1'b1;
          state_d   = ST_READOUT;
        end
      end

      ST_READOUT: begin
        if (rd_ptr_q != count_q) begin
          if (bus.i_rd_req) begin
            rd_en_c   = 1'b1;
            rd_ptr_d  = rd_ptr_q + CW'(1);
            rd_pend_d = 1'b1;
          end
        end else if (!rd_pend_q && rd_valid_q) begin
          // Final sample is on the port this cycle; return to idle afterwards.
          state_d     = ST_IDLE;
          count_d     = '0;
          rd_ptr_d    = '0;
          full_d      = 1'b0;
          trig_pos_d  = '0;
          trig_seen_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE) || (state_d == ST_READOUT);
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (internal_reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      full_q      <= 1'b0;
      trig_pos_q  <= '0;
      trig_seen_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CAPTURE_DECIM_EN
      pre_q       <= 8'd0;
      trig_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      trig_pos_q  <= trig_pos_d;
      trig_seen_q <= trig_seen_d;
      rd_pend_q   <= rd_pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_pend_q ? ram_q : '0;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CAPTURE_DECIM_EN
      pre_q       <= pre_d;
      trig_pend_q <= trig_pend_d;
`endif
    end
  end

  // Sample RAM: synchronous write, registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c && !internal_reset) begin
      mem[wr_addr_c] <= bus.i_data;
    end
    if (rd_en_c) begin
      ram_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_full      = full_q;
  assign bus.o_count     = count_q;
  assign bus.o_trig_pos  = trig_pos_q;
  assign bus.o_trig_seen = trig_seen_q;

endmodule
